// File: rtl/uart_frame_scheduler.sv
// Frames captured I2C bytes and heartbeat counters onto a byte-wide UART.
// Capture bytes queue in a FIFO; an FSM alternates capture and heartbeat frames.
module uart_frame_scheduler #(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] HDR_CAP    = 8'hA5,
  parameter logic [7:0] HDR_HB     = 8'h5A
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [7:0]                          in_data,
  input  logic                                in_last,
  input  logic                                hb_req,
  input  logic                                tx_busy,
  input  logic                                uart_tx_done,
  output logic                                uart_tx_en,
  output logic [7:0]                          uart_tx_data,
  output logic [7:0]                          drop_cnt,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
  output logic                                busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_DATA = LW'(FIFO_DEPTH - 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_LOAD, S_SEND, S_GAP} state_t;
  typedef enum logic [1:0] {PH_HDR, PH_PAYLOAD, PH_CSUM, PH_CNT} phase_t;

  state_t          state, state_nxt;
  phase_t          phase, phase_nxt;

  logic [8:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   eof_cnt;
  logic [8:0]      head;
  logic            push, pop, cap_req;

  logic            hb_pend, last_grant_hb, frame_hb, grant_hb;
  logic            loaded, load_fire, eof_sent;
  logic [7:0]      csum, load_byte;

  assign head    = mem[rd_ptr];
  assign cap_req = (eof_cnt != '0);

  // The top slot only takes a last byte, so a full FIFO always ends in a frame.
  assign push = in_valid && (in_last ? (fifo_level < LVL_FULL) : (fifo_level < LVL_DATA));

  // NOTE: payload storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_data};
  end

  // NOTE: every sequential assignment is non-blocking so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      eof_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      case ({push && in_last, pop && head[8]})
        2'b10:   eof_cnt <= eof_cnt + LW'(1);
        2'b01:   eof_cnt <= eof_cnt - LW'(1);
        default: eof_cnt <= eof_cnt;
      endcase
      if (in_valid && !push && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      phase <= PH_HDR;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    // NOTE: defaults first keep every path assigned, so no latch is inferred.
    state_nxt = state;
    phase_nxt = phase;
    unique case (state)
      S_IDLE: if (cap_req || hb_pend) state_nxt = S_ARB;
      S_ARB: begin
        state_nxt = S_LOAD;
        phase_nxt = PH_HDR;
      end
      S_LOAD: if (!tx_busy) state_nxt = S_SEND;
      S_SEND: if (uart_tx_done) state_nxt = S_GAP;
      S_GAP: begin
        state_nxt = S_LOAD;
        unique case (phase)
          PH_HDR:     phase_nxt = frame_hb ? PH_CNT : PH_PAYLOAD;
          PH_PAYLOAD: if (eof_sent) phase_nxt = PH_CSUM;
          default:    state_nxt = S_IDLE;
        endcase
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs and per-phase byte selection
  always_comb begin
    busy      = (state != S_IDLE);
    grant_hb  = hb_pend && (!cap_req || !last_grant_hb);
    load_fire = (state == S_LOAD) && !loaded;
    pop       = load_fire && (phase == PH_PAYLOAD);
    load_byte = 8'h00;
    unique case (phase)
      PH_HDR:     load_byte = frame_hb ? HDR_HB : HDR_CAP;
      PH_PAYLOAD: load_byte = head[7:0];
      PH_CSUM:    load_byte = csum;
      PH_CNT:     load_byte = drop_cnt;
      default:    load_byte = 8'h00;
    endcase
  end

  // Frame bookkeeping and registered UART outputs; the byte is captured once per LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_pend       <= 1'b0;
      last_grant_hb <= 1'b1;
      frame_hb      <= 1'b0;
      loaded        <= 1'b0;
      eof_sent      <= 1'b0;
      csum          <= 8'h00;
      uart_tx_en    <= 1'b0;
      uart_tx_data  <= 8'h00;
    end else begin
      loaded     <= (state == S_LOAD);
      uart_tx_en <= (state_nxt == S_SEND);
      if (state == S_ARB && grant_hb) hb_pend <= 1'b0;
      else if (hb_req)                hb_pend <= 1'b1;
      if (state == S_ARB) begin
        frame_hb      <= grant_hb;
        last_grant_hb <= grant_hb;
        csum          <= 8'h00;
        eof_sent      <= 1'b0;
      end
      if (load_fire) begin
        uart_tx_data <= load_byte;
        if (pop) begin
          csum     <= csum ^ head[7:0];
          eof_sent <= head[8];
        end
      end
    end
  end

endmodule

// File: doc/uart_frame_scheduler.md
UART_FRAME_SCHEDULER -- requirements
Module: uart_frame_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, capture FIFO entries of 9 bits ({eof, byte}).
REQ-002 SHALL have parameter HDR_CAP, default 8'hA5, capture-frame header byte.
REQ-003 SHALL have parameter HDR_HB, default 8'h5A, heartbeat-frame header byte.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  capture byte strobe, one byte per cycle.
REQ-007 SHALL have port in_data  input  8  captured I2C byte (address, register or data).
REQ-008 SHALL have port in_last  input  1  qualifies in_data as the final byte of a transaction.
REQ-009 SHALL have port hb_req  input  1  heartbeat request pulse.
REQ-010 SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-011 SHALL have port uart_tx_done  input  1  one-cycle pulse: current byte transmitted.
REQ-012 SHALL have port uart_tx_en  output  1  transmit request, registered.
REQ-013 SHALL have port uart_tx_data  output  8  byte to transmit, registered.
REQ-014 SHALL have port drop_cnt  output  8  dropped capture bytes, saturating at 255.
REQ-015 SHALL have port fifo_level  output  5  current FIFO occupancy, 0..16.
REQ-016 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 FIFO push rule, evaluated on pre-edge fifo_level: non-last byte accepted only if level<15; last byte accepted only if level<16; else dropped and drop_cnt increments (saturating).
REQ-018 Slot 16 is reserved for a last byte, so the tail entry is always eof-marked when level==16 and every enqueued frame terminates.
REQ-019 Simultaneous push and pop SHALL both take effect; level unchanged.
REQ-020 eof_cnt SHALL count eof entries in the FIFO: +1 on eof push, -1 on eof pop, unchanged when both occur in one cycle.
REQ-021 hb_req SHALL set a sticky hb_pend flag; further requests while pending merge into it; flag clears on entering the heartbeat header LOAD.
REQ-022 Capture frame SHALL be: HDR_CAP, payload bytes in FIFO order through the eof entry, then checksum = XOR of the payload bytes, initial 8'h00.
REQ-023 Heartbeat frame SHALL be: HDR_HB, then the drop_cnt value sampled on the cycle its LOAD is entered.
REQ-024 FSM states SHALL be IDLE, ARB, LOAD, SEND, GAP; sub-phase register HDR/PAYLOAD/CSUM (capture) or HDR/CNT (heartbeat).
REQ-025 IDLE->ARB when eof_cnt>0 or hb_pend.
REQ-026 ARB: one requester pending -> grant it; both pending -> grant the one not granted last (last_grant flag); -> LOAD phase HDR.
REQ-027 LOAD: drive uart_tx_data with the phase byte; PAYLOAD phase pops the FIFO head in this cycle and XORs it into the checksum; leave to SEND only when tx_busy==0, else hold.
REQ-028 SEND: uart_tx_en=1 and uart_tx_data stable until uart_tx_done sampled 1; next cycle uart_tx_en=0, state GAP.
REQ-029 GAP: one cycle, uart_tx_en=0; advance phase (PAYLOAD repeats until the eof byte is sent) -> LOAD, or at end of frame -> IDLE.
REQ-030 uart_tx_en SHALL be high only in SEND; frames are never interleaved; push acceptance continues during transmission.
REQ-031 uart_tx_done outside SEND SHALL be ignored.
REQ-032 Per-byte minimum spacing: LOAD(1) + SEND(>=1) + GAP(1) cycles.

Reset
REQ-033 On rst: state IDLE, FIFO emptied, eof_cnt=0, fifo_level=0, hb_pend=0, last_grant=heartbeat (capture wins first tie), checksum=0, uart_tx_en=0, uart_tx_data=0, drop_cnt=0, busy=0.
REQ-034 Reset asserted mid-frame SHALL drop uart_tx_en immediately and discard the partial frame; no resumption after release.

Verification
REQ-035 Push 8'h50, 8'h10, 8'h3C(last); tx_done 4 cycles after each tx_en -> tx bytes A5,50,10,3C,7C; tx_en low in each GAP cycle.
REQ-036 Push 20 non-last bytes then one last byte, no drain -> 15 accepted, 5 dropped, last accepted, fifo_level=16, drop_cnt=5.
REQ-037 hb_req pulse 3 times during a capture frame -> one heartbeat frame 5A, drop_cnt after capture frame completes.
REQ-038 Capture frame and hb_pend both pending from reset -> capture first, heartbeat next; at the following tie heartbeat is skipped for capture only if heartbeat was granted last.
REQ-039 Hold tx_busy=1 during LOAD for 10 cycles -> tx_en stays 0 and tx_data stable; tx_en rises the cycle after tx_busy falls.
REQ-040 Assert rst during SEND of payload byte 2 -> tx_en 0 same cycle, fifo_level 0, drop_cnt 0; after release no bytes sent until new input.
